axi_wr_fifo_router: RTL
=======================

// Module: axi_wr_fifo_router
// PURPOSE
//  AXI4 write-only slave that decodes each write burst's address into one of NUM_CH push channels.
//  Streams every data beat into that channel's input FIFO, tagged with a shared message index.
//  Parametrised, burst-capable successor of the single-beat two-channel write FSM.
//  Sits between the HPS/fabric AXI interconnect and the accelerator input FIFOs.
// PARAMETERS
//  DATA_W    32  wdata width (bits); STRB_W = DATA_W/8
//  ID_W      4   AXI ID width
//  NUM_CH    2   number of push channels (1..16)
//  IDX_W     10  message index width; wraps 2^IDX_W-1 -> 0
//  CH_LSB    4   awaddr[CH_LSB+3:CH_LSB] = channel select; awaddr[0] = LAST flag
// PORTS
//  clk           in   1            clock
//  reset         in   1            synchronous, active-high
//  s_awid        in   ID_W         write address ID
//  s_awaddr      in   32           write address
//  s_awlen       in   8            beats-1
//  s_awvalid     in   1            / s_awready  out 1: AW handshake
//  s_wdata       in   DATA_W       write data
//  s_wstrb       in   STRB_W       byte strobes
//  s_wlast       in   1            last beat marker
//  s_wvalid      in   1            / s_wready   out 1: W handshake
//  s_bid         out  ID_W         response ID (captured awid)
//  s_bresp       out  2            2'b00 OKAY, 2'b10 SLVERR
//  s_bvalid      out  1            / s_bready   in  1: B handshake
//  ch_full       in   NUM_CH       per-channel FIFO full
//  ch_clr        out  NUM_CH       per-channel FIFO+index+strb clear
//  ch_push       out  NUM_CH       one-hot push strobe
//  push_data     out  DATA_W       = s_wdata of accepted beat
//  push_strb     out  STRB_W       = s_wstrb of accepted beat
//  push_index    out  IDX_W        current message index
//  push_last     out  1            beat is last of a LAST-flagged burst
// BEHAVIOUR
//  Reset: state INIT; all ready/valid/push/clr outputs 0; s_bresp 0; index, captured regs 0.
//  States: INIT -> IDLE -> DATA -> RESP -> IDLE.
//  INIT (1 cycle): ch_clr all ones; index cleared.
//  IDLE: s_awready=1; on awvalid capture awid, channel sel, LAST flag, beat count = awlen.
//   err=1 if sel >= NUM_CH; go DATA.
//  DATA: s_wready = err | ~ch_full[sel].
//   Full FIFO stalls only the W channel; no separate full state.
//   Beat accepted (wvalid&wready): if ~err, ch_push[sel]=1 in the same cycle (zero latency).
//    Push data/strb/index are combinational from the beat and index register.
//   Per accepted beat: count decrements; after count==0 beat go RESP.
//   wlast mismatch (wlast != (count==0)) sets err_wlast; beats are still consumed by count.
//  RESP: s_bvalid=1, held with stable s_bid/s_bresp until bready; then IDLE.
//   bresp = SLVERR if err|err_wlast else OKAY.
//   On entry cycle, if LAST flag & ~err: index <= index+1 (wraps to 0 at max).
//   This is one increment per burst, never per beat.
//  Error bursts: all beats drained with wready=1, no pushes, index unchanged.
//  push_last=1 only on the final beat of a LAST-flagged, non-error burst.
//  No AW accepted outside IDLE (single outstanding write). bvalid never asserted in IDLE/DATA.
//  Reset mid-burst: immediate return to INIT next edge, no response issued, channels cleared.
//  Unknown state encoding -> INIT.
// STRUCTURE
//  Shared package fw_axi_pkg: AXI_RESP_OKAY/SLVERR constants and state enum for this router.
//  One sub-module natural: fw_idx_counter (clr, inc, wrap at 2^IDX_W-1), reusable by read-side routers.
//  Decode, FSM and push muxing stay in this module; push outputs are not registered.
// TESTING
//  awaddr=0x00, awlen=0, one beat 0xDEADBEEF strb F -> ch_push=01 same cycle, bresp 00, index stays 0.
//  awaddr=0x11 (ch1, LAST), awlen=3, 4 beats -> 4 pushes on ch_push=10, push_last on beat 4 only.
//   Index 0 -> 1 after the burst.
//  ch_full[0]=1 for 5 cycles mid-burst -> wready=0 those cycles, no push; burst completes after release.
//  awaddr=0xF0 with NUM_CH=2 (sel 15), awlen=1 -> 2 beats drained, no push, bresp=10, index unchanged.
//  Hold bready=0 for 3 cycles -> bvalid/bid/bresp stable, awready=0 until B handshake.
//  1024 LAST writes -> index wraps 1023 -> 0.
//  reset mid-DATA -> next cycle ch_clr all ones, no bvalid.

Source files
------------

// File: rtl/fw_axi_pkg.sv
// Shared AXI constants and the write-router state type used by the FIFO routers.
package fw_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        RTR_INIT = 2'd0,
        RTR_IDLE = 2'd1,
        RTR_DATA = 2'd2,
        RTR_RESP = 2'd3
    } wr_rtr_state_e;

endpackage

// File: rtl/axi_wr_fifo_router_if.sv
// AXI4 write-only channel bundle (AW, W, B) between the interconnect and the router.
interface axi_wr_fifo_router_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) ();
    localparam int STRB_W = DATA_W / 8;

    logic [ID_W-1:0]   s_awid;
    logic [31:0]       s_awaddr;
    logic [7:0]        s_awlen;
    logic              s_awvalid;
    logic              s_awready;
    logic [DATA_W-1:0] s_wdata;
    logic [STRB_W-1:0] s_wstrb;
    logic              s_wlast;
    logic              s_wvalid;
    logic              s_wready;
    logic [ID_W-1:0]   s_bid;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;

    modport slave (
        input  s_awid, s_awaddr, s_awlen, s_awvalid,
        output s_awready,
        input  s_wdata, s_wstrb, s_wlast, s_wvalid,
        output s_wready,
        output s_bid, s_bresp, s_bvalid,
        input  s_bready
    );

    modport master (
        output s_awid, s_awaddr, s_awlen, s_awvalid,
        input  s_awready,
        output s_wdata, s_wstrb, s_wlast, s_wvalid,
        input  s_wready,
        input  s_bid, s_bresp, s_bvalid,
        output s_bready
    );

endinterface

// File: rtl/fw_idx_counter.sv
// Message index counter: clear has priority, increments wrap from all-ones back to zero.
module fw_idx_counter #(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [IDX_W-1:0] idx_o
);

    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/axi_wr_fifo_router.sv
// AXI4 write slave that routes each burst's beats to one of NUM_CH push FIFOs,
// tagging them with a message index that advances once per LAST-flagged burst.
module axi_wr_fifo_router
    import fw_axi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 10,
    parameter int CH_LSB = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    axi_wr_fifo_router_if.slave   s_axi,
    input  logic [NUM_CH-1:0]     ch_full,
    output logic [NUM_CH-1:0]     ch_clr,
    output logic [NUM_CH-1:0]     ch_push,
    output logic [DATA_W-1:0]     push_data,
    output logic [DATA_W/8-1:0]   push_strb,
    output logic [IDX_W-1:0]      push_index,
    output logic                  push_last
);

    localparam logic [4:0] NUM_CH_V = 5'(NUM_CH);

    wr_rtr_state_e   state_q, state_d;
    logic [ID_W-1:0] awid_q, awid_d;
    logic [3:0]      sel_q, sel_d;
    logic            last_flag_q, last_flag_d;
    logic [7:0]      count_q, count_d;
    logic            err_q, err_d;
    logic            err_wlast_q, err_wlast_d;

    logic            awready_c, wready_c, bvalid_c, clr_c;
    logic [1:0]      bresp_c;
    logic            push_en, beat_last, idx_clr, idx_inc;
    logic [3:0]      aw_sel;
    logic [NUM_CH-1:0] sel_onehot;
    logic            full_sel;
    logic            unused_addr;

    assign aw_sel      = s_axi.s_awaddr[CH_LSB+3:CH_LSB];
    assign unused_addr = ^s_axi.s_awaddr;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sel
        assign sel_onehot[gi] = (sel_q == 4'(gi));
    end

    // An out-of-range select never matches a channel, so its full flag reads as 0.
    assign full_sel = |(ch_full & sel_onehot);

    always_comb begin
        state_d     = state_q;
        awid_d      = awid_q;
        sel_d       = sel_q;
        last_flag_d = last_flag_q;
        count_d     = count_q;
        err_d       = err_q;
        err_wlast_d = err_wlast_q;
        awready_c   = 1'b0;
        wready_c    = 1'b0;
        bvalid_c    = 1'b0;
        bresp_c     = AXI_RESP_OKAY;
        clr_c       = 1'b0;
        push_en     = 1'b0;
        beat_last   = 1'b0;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        if (!reset) begin
            case (state_q)
                RTR_INIT: begin
                    clr_c   = 1'b1;
                    idx_clr = 1'b1;
                    state_d = RTR_IDLE;
                end
                RTR_IDLE: begin
                    awready_c = 1'b1;
                    if (s_axi.s_awvalid) begin
                        awid_d      = s_axi.s_awid;
                        sel_d       = aw_sel;
                        last_flag_d = s_axi.s_awaddr[0];
                        count_d     = s_axi.s_awlen;
                        err_d       = ({1'b0, aw_sel} >= NUM_CH_V);
                        err_wlast_d = 1'b0;
                        state_d     = RTR_DATA;
                    end
                end
                RTR_DATA: begin
                    wready_c  = err_q | ~full_sel;
                    beat_last = (count_q == 8'd0);
                    if (s_axi.s_wvalid && wready_c) begin
                        push_en = ~err_q;
                        // The burst length from AW is authoritative; wlast only flags errors.
                        if (s_axi.s_wlast != beat_last) begin
                            err_wlast_d = 1'b1;
                        end
                        if (beat_last) begin
                            idx_inc = last_flag_q & ~err_q;
                            state_d = RTR_RESP;
                        end else begin
                            count_d = count_q - 8'd1;
                        end
                    end
                end
                RTR_RESP: begin
                    bvalid_c = 1'b1;
                    bresp_c  = (err_q | err_wlast_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    if (s_axi.s_bready) begin
                        state_d = RTR_IDLE;
                    end
                end
                default: state_d = RTR_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RTR_INIT;
            awid_q      <= '0;
            sel_q       <= '0;
            last_flag_q <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
            err_wlast_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            awid_q      <= awid_d;
            sel_q       <= sel_d;
            last_flag_q <= last_flag_d;
            count_q     <= count_d;
            err_q       <= err_d;
            err_wlast_q <= err_wlast_d;
        end
    end

    fw_idx_counter #(
        .IDX_W (IDX_W)
    ) u_idx (
        .clk   (clk),
        .reset (reset),
        .clr_i (idx_clr),
        .inc_i (idx_inc),
        .idx_o (push_index)
    );

    assign s_axi.s_awready = awready_c;
    assign s_axi.s_wready  = wready_c;
    assign s_axi.s_bvalid  = bvalid_c;
    assign s_axi.s_bresp   = bresp_c;
    assign s_axi.s_bid     = awid_q;

    assign ch_clr    = {NUM_CH{clr_c}};
    assign ch_push   = push_en ? sel_onehot : '0;
    assign push_data = s_axi.s_wdata;
    assign push_strb = s_axi.s_wstrb;
    assign push_last = push_en & last_flag_q & beat_last;

endmodule
